aer_addr_scan_tx: RTL

Address-event transmitter for the landscape-sampling path. On `start` it latches the final address `addr_fin` from the address-input tracker, then walks the landscape memory from address 0 to `addr_fin` inclusive. For each entry with a nonzero weight it emits that many address events on an off-chip 4-phase req/ack AER bus. It is the output-side counterpart of the address-capture logic: that logic records how far the landscape was written, and this block reads it back out as events.

---
 rtl/aer_addr_scan_tx.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/aer_addr_scan_tx.sv
// rtl/aer_addr_scan_tx.sv - landscape memory scan to 4-phase AER event transmitter
module aer_addr_scan_tx #(
  parameter int bit_addr = 9,
  parameter int bit_w    = 8,
  parameter int bit_cnt  = 16
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start_i,
  input  logic [bit_addr-1:0] addr_fin_i,
  output logic                mem_rd_o,
  output logic [bit_addr-1:0] mem_addr_o,
  input  logic [bit_w-1:0]    mem_data_i,
  output logic [bit_addr-1:0] aer_addr_o,
  output logic                aer_req_o,
  input  logic                aer_ack_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [bit_cnt-1:0]  ev_count_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CHECK,
    S_REQ,
    S_WAIT_HI,
    S_WAIT_LO,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [bit_addr-1:0] addr_one = 1;
  localparam logic [bit_w-1:0]    w_one    = 1;
  localparam logic [bit_cnt-1:0]  cnt_one  = 1;

  state_t              state_q;
  logic                ack_s1_q;
  logic                ack_s_q;
  logic [bit_addr-1:0] a_q;
  logic [bit_addr-1:0] fin_q;
  logic [bit_w-1:0]    rep_q;
  logic [bit_addr-1:0] mem_addr_q;
  logic                mem_rd_q;
  logic [bit_addr-1:0] aer_addr_q;
  logic                aer_req_q;
  logic                busy_q;
  logic                done_q;
  logic [bit_cnt-1:0]  ev_count_q;

  // Two-flop synchronizer: aer_ack comes from an off-chip receiver in another clock domain
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ack_s1_q <= 1'b0;
      ack_s_q  <= 1'b0;
    end else begin
      ack_s1_q <= aer_ack_i;
      ack_s_q  <= ack_s1_q;
    end
  end

  // Scan/handshake FSM; every output is a register updated on the transition that implies it
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      fin_q      <= '0;
      rep_q      <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      aer_addr_q <= '0;
      aer_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ev_count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            fin_q      <= addr_fin_i;
            a_q        <= '0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b1;
            ev_count_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_READ;
          end
        end

        S_READ: begin
          mem_rd_q <= 1'b0;
          state_q  <= S_CHECK;
        end

        S_CHECK: begin
          if (mem_data_i == '0) begin
            state_q <= S_NEXT;
          end else begin
            rep_q <= mem_data_i;
            // The bus address may only move while the receiver's ack is low;
            // a stale ack defers the update to REQ.
            if (!ack_s_q) begin
              aer_addr_q <= a_q;
            end
            state_q <= S_REQ;
          end
        end

        S_REQ: begin
          if (!ack_s_q) begin
            if (aer_addr_q == a_q) begin
              aer_req_q <= 1'b1;
              state_q   <= S_WAIT_HI;
            end else begin
              // Address set up one cycle ahead of the request edge
              aer_addr_q <= a_q;
            end
          end
        end

        S_WAIT_HI: begin
          if (ack_s_q) begin
            aer_req_q <= 1'b0;
            rep_q     <= rep_q - w_one;
            if (ev_count_q != '1) begin
              ev_count_q <= ev_count_q + cnt_one;
            end
            state_q <= S_WAIT_LO;
          end
        end

        S_WAIT_LO: begin
          if (!ack_s_q) begin
            state_q <= (rep_q != '0) ? S_REQ : S_NEXT;
          end
        end

        S_NEXT: begin
          // Compare before incrementing so a full-range scan never wraps to 0
          if (a_q == fin_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            a_q        <= a_q + addr_one;
            mem_addr_q <= a_q + addr_one;
            mem_rd_q   <= 1'b1;
            state_q    <= S_READ;
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_rd_o   = mem_rd_q;
  assign mem_addr_o = mem_addr_q;
  assign aer_addr_o = aer_addr_q;
  assign aer_req_o  = aer_req_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign ev_count_o = ev_count_q;

endmodule
